// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decode stage.
// Owns the program counter. Runs a req/ack read handshake with program memory,
// buffers fetched bytes in a small FIFO and presents them to decode through a
// valid/ready handshake. Supports jump redirects and halts after a STOP opcode.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   mem_req, mem_addr     read request and address (held stable until mem_ack)
//   mem_ack, mem_rdata    memory accept and read data (same cycle)
//   instr_valid, instr,   FIFO head: valid flag, instruction byte and
//   instr_pc              the address it was fetched from
//   instr_ready           decode consumes the head when valid && ready
//   jump_en, jump_addr    single-cycle redirect strobe and target
//   halted                STOP fetched, no further requests until jump/reset
//   pc                    address of the next word to request
module fetch_unit #(
   parameter int unsigned        ADDR_W   = 8,
   parameter int unsigned        DATA_W   = 8,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter int unsigned        DEPTH    = 2,
   parameter logic [DATA_W-1:0]  STOP_OP  = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic              halted,
   output logic [ADDR_W-1:0] pc
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2,
      HALT    = 2'd3
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;

   logic pop;
   logic push;

   // A jump voids any pop and any push in its cycle.
   assign pop  = (count != '0) && instr_ready && !jump_en;
   assign push = (state == REQ) && mem_ack && !jump_en;

   // FIFO head is read straight out of the storage registers.
   assign instr_valid = (count != '0);
   assign instr       = data_q[rd_ptr];
   assign instr_pc    = addr_q[rd_ptr];

   // FIFO storage and pointers; a jump flushes the queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= '0;
            addr_q[i] <= '0;
         end
      end else if (jump_en) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            data_q[wr_ptr] <= mem_rdata;
            addr_q[wr_ptr] <= mem_addr;
            wr_ptr         <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Fetch control FSM with registered memory-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         mem_req  <= 1'b0;
         mem_addr <= RESET_PC;
         pc       <= RESET_PC;
         halted   <= 1'b0;
      end else if (jump_en) begin
         pc     <= jump_addr;
         halted <= 1'b0;
         // An unacked request cannot be withdrawn: keep it up and drop its data later.
         if (((state == REQ) || (state == DISCARD)) && !mem_ack) begin
            state <= DISCARD;
         end else begin
            state   <= IDLE;
            mem_req <= 1'b0;
         end
      end else begin
         case (state)
            IDLE: begin
               // Only issue when the ack push is guaranteed a free slot.
               if (count < CNT_W'(DEPTH)) begin
                  mem_req  <= 1'b1;
                  mem_addr <= pc;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  pc      <= mem_addr + ADDR_W'(1);
                  if (mem_rdata == STOP_OP) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DISCARD: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed bench for fetch_unit with a
// transaction-level reference model (expected instruction queue, pc, halt flag).
module tb_fetch_unit;

   localparam int unsigned DEPTH = 2;

   logic       clk;
   logic       rst;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic       mem_ack;
   logic [7:0] mem_rdata;
   logic       instr_valid;
   logic [7:0] instr;
   logic [7:0] instr_pc;
   logic       instr_ready;
   logic       jump_en;
   logic [7:0] jump_addr;
   logic       halted;
   logic [7:0] pc;

   fetch_unit #(
      .ADDR_W   (8),
      .DATA_W   (8),
      .RESET_PC (8'h00),
      .DEPTH    (DEPTH),
      .STOP_OP  (8'h00)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .halted      (halted),
      .pc          (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_errors;

   // Program memory and reference model state.
   logic [7:0]  mem [256];
   logic [15:0] q [$];          // expected FIFO contents: {addr, data}
   logic [7:0]  m_pc;
   logic [7:0]  m_req_addr;
   bit          m_halted;
   bit          m_discard;
   bit          prev_req;
   bit          prev_acc;
   bit          prev_jump;
   int          prev_qsize;

   // Stimulus controls.
   int  wait_cnt;
   int  cur_dly;
   int  force_dly;
   int  rdy_mode;               // 0: never ready, 1: always ready, 2: random
   bit  rand_jump;
   bit  jump_when_ack;
   bit  ack_jump_done;
   int  acc_count;
   logic [15:0] pop_log [$];
   logic [7:0]  issue_log [$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compare settled DUT outputs against the model.
   task automatic check_outputs();
      check_val("halted", 32'(halted), 32'(m_halted));
      check_val("pc", 32'(pc), 32'(m_pc));
      check_val("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check_val("instr", 32'(instr), 32'(q[0][7:0]));
         check_val("instr_pc", 32'(instr_pc), 32'(q[0][15:8]));
      end
      if (m_halted) check_val("req_in_halt", 32'(mem_req), 32'(0));
      if (prev_acc) check_val("drop_after_ack", 32'(mem_req), 32'(0));
      if (prev_req && !prev_acc) check_val("req_held", 32'(mem_req), 32'(1));
      if (mem_req) begin
         if (!prev_req) begin
            check_val("req_addr", 32'(mem_addr), 32'(m_pc));
            check_val("req_room", 32'(prev_qsize < int'(DEPTH)), 32'(1));
            check_val("req_after_jump", 32'(prev_jump), 32'(0));
            m_req_addr = m_pc;
            issue_log.push_back(mem_addr);
         end else begin
            check_val("addr_hold", 32'(mem_addr), 32'(m_req_addr));
         end
      end
   endtask

   // One clock cycle: check, drive inputs, advance model, wait for next negedge.
   task automatic step(input bit jmp_in, input logic [7:0] ja_in);
      bit         jmp;
      bit         acc;
      bit         pop;
      logic [7:0] ja;
      jmp = jmp_in;
      ja  = ja_in;
      check_outputs();
      mem_rdata = mem[mem_addr];
      mem_ack   = mem_req && (wait_cnt >= cur_dly);
      case (rdy_mode)
         0:       instr_ready = 1'b0;
         1:       instr_ready = 1'b1;
         default: instr_ready = 1'($urandom_range(0, 1));
      endcase
      if (jump_when_ack && mem_ack) begin
         jmp = 1'b1;
         ja  = 8'h20;
         jump_when_ack = 1'b0;
         ack_jump_done = 1'b1;
      end
      if (rand_jump && ($urandom_range(0, 99) < 3)) begin
         jmp = 1'b1;
         ja  = 8'($urandom);
      end
      jump_en   = jmp;
      jump_addr = ja;

      acc = mem_req && mem_ack;
      pop = (q.size() != 0) && instr_ready && !jmp;
      prev_qsize = q.size();
      prev_jump  = jmp;
      prev_req   = mem_req;
      prev_acc   = acc;
      if (acc) acc_count++;
      if (jmp) begin
         q.delete();
         m_pc      = ja;
         m_halted  = 1'b0;
         m_discard = mem_req && !mem_ack;
      end else begin
         if (pop) begin
            pop_log.push_back({instr_pc, instr});
            void'(q.pop_front());
         end
         if (acc) begin
            if (m_discard) begin
               m_discard = 1'b0;
            end else begin
               q.push_back({m_req_addr, mem[m_req_addr]});
               m_pc = m_req_addr + 8'd1;
               if (mem[m_req_addr] == 8'h00) m_halted = 1'b1;
            end
         end
      end
      if (mem_req && !mem_ack) begin
         wait_cnt++;
      end else begin
         wait_cnt = 0;
         cur_dly  = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_ack = 1'b0;
      mem_rdata = 8'h00;
      jump_en = 1'b0;
      jump_addr = 8'h00;
      instr_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val("rst_mem_req", 32'(mem_req), 32'(0));
      check_val("rst_mem_addr", 32'(mem_addr), 32'(0));
      check_val("rst_pc", 32'(pc), 32'(0));
      check_val("rst_valid", 32'(instr_valid), 32'(0));
      check_val("rst_instr", 32'(instr), 32'(0));
      check_val("rst_instr_pc", 32'(instr_pc), 32'(0));
      check_val("rst_halted", 32'(halted), 32'(0));
      rst = 1'b0;
      q.delete();
      m_pc = 8'h00;
      m_req_addr = 8'h00;
      m_halted = 1'b0;
      m_discard = 1'b0;
      prev_req = 1'b0;
      prev_acc = 1'b0;
      prev_jump = 1'b0;
      prev_qsize = 0;
      wait_cnt = 0;
      cur_dly = (force_dly >= 0) ? force_dly : 1;
      pop_log.delete();
      issue_log.delete();
      acc_count = 0;
      jump_when_ack = 1'b0;
      ack_jump_done = 1'b0;
   endtask

   initial begin
      int  n0;
      bit  found;
      n_checks = 0;
      n_errors = 0;
      rand_jump = 1'b0;
      force_dly = 1;
      rdy_mode = 1;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h41);

      // Basic fetch: bytes 41, 42 at addresses 0, 1.
      do_reset();
      step(1'b0, 8'h00);
      check_val("t1_req_cycle1", 32'(mem_req), 32'(1));
      check_val("t1_addr0", 32'(mem_addr), 32'(0));
      run(10);
      check_val("t1_pops", 32'(pop_log.size() >= 2), 32'(1));
      if (pop_log.size() >= 2) begin
         check_val("t1_pop0", 32'(pop_log[0]), 32'(16'h0041));
         check_val("t1_pop1", 32'(pop_log[1]), 32'(16'h0142));
      end

      // Backpressure: FIFO fills after two fetches, one pop frees one slot.
      rdy_mode = 0;
      do_reset();
      run(20);
      check_val("t2_acks", 32'(acc_count), 32'(2));
      check_val("t2_req_idle", 32'(mem_req), 32'(0));
      rdy_mode = 1;
      step(1'b0, 8'h00);
      rdy_mode = 0;
      run(10);
      check_val("t2_acks_after_pop", 32'(acc_count), 32'(3));
      check_val("t2_issue_cnt", 32'(issue_log.size()), 32'(3));
      if (issue_log.size() == 3) check_val("t2_addr2", 32'(issue_log[2]), 32'(2));

      // STOP at address 3 halts; jump restarts fetching.
      mem[3] = 8'h00;
      rdy_mode = 1;
      do_reset();
      run(20);
      check_val("t3_halted", 32'(halted), 32'(1));
      check_val("t3_no_req", 32'(mem_req), 32'(0));
      found = 1'b0;
      foreach (pop_log[i]) if (pop_log[i] == 16'h0300) found = 1'b1;
      check_val("t3_stop_popped", 32'(found), 32'(1));
      n0 = issue_log.size();
      step(1'b1, 8'h10);
      run(5);
      check_val("t3_unhalted", 32'(halted), 32'(0));
      check_val("t3_reissue", 32'(issue_log.size() > n0), 32'(1));
      if (issue_log.size() > n0) check_val("t3_jump_addr", 32'(issue_log[n0]), 32'(8'h10));

      // Jump while a slow request to address 5 is pending.
      force_dly = 3;
      do_reset();
      step(1'b1, 8'h05);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (mem_req && mem_addr == 8'h05) found = 1'b1;
         else step(1'b0, 8'h00);
      end
      check_val("t4_req5_seen", 32'(found), 32'(1));
      n0 = issue_log.size() + 1;   // rise at addr 5 is logged by the next step
      step(1'b1, 8'h80);
      run(20);
      check_val("t4_reissue", 32'(issue_log.size() > n0), 32'(1));
      if (issue_log.size() > n0) check_val("t4_addr80", 32'(issue_log[n0]), 32'(8'h80));
      found = 1'b0;
      foreach (pop_log[i]) if (pop_log[i][15:8] == 8'h05) found = 1'b1;
      check_val("t4_no_pc5", 32'(found), 32'(0));

      // Jump coincident with ack: byte never becomes valid.
      force_dly = 1;
      do_reset();
      jump_when_ack = 1'b1;
      for (int i = 0; i < 10 && !ack_jump_done; i++) step(1'b0, 8'h00);
      check_val("t5_jump_done", 32'(ack_jump_done), 32'(1));
      check_val("t5_empty", 32'(instr_valid), 32'(0));
      run(10);
      found = 1'b0;
      foreach (pop_log[i]) if (pop_log[i][15:8] == 8'h00) found = 1'b1;
      check_val("t5_no_pc0", 32'(found), 32'(0));

      // PC wrap from FF to 00.
      do_reset();
      step(1'b1, 8'hFF);
      run(12);
      check_val("t6_pops", 32'(pop_log.size() >= 1), 32'(1));
      if (pop_log.size() >= 1) check_val("t6_popff", 32'(pop_log[0]), 32'(16'hFF40));
      check_val("t6_issues", 32'(issue_log.size() >= 2), 32'(1));
      if (issue_log.size() >= 2) check_val("t6_wrap_addr", 32'(issue_log[1]), 32'(0));

      // Reset while a request is outstanding.
      force_dly = 3;
      do_reset();
      run(2);
      check_val("t7_req_before_rst", 32'(mem_req), 32'(1));
      do_reset();

      // Random traffic: random delays, readiness, jumps and STOP bytes.
      for (int i = 0; i < 256; i++) begin
         mem[i] = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      end
      force_dly = -1;
      rdy_mode = 2;
      rand_jump = 1'b1;
      do_reset();
      run(3000);
      check_val("rand_progress", 32'(acc_count > 100), 32'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
